seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse operation of the team's multiplier datapath.
- Produces one quotient bit per clock, so a WIDTH-bit divide completes in WIDTH cycles.
- Uses a start/busy/done handshake so it can sit beside the multiplier in the arithmetic unit and share the same controller.
- Intended for area-constrained paths where a combinational array divider is too large.

---
 rtl/div_pkg.sv | 25 ++
 rtl/seq_divider_if.sv | 25 ++
 rtl/sub_borrow.sv | 14 +
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count down from value-1 to zero.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/sub_borrow.sv
// Combinational subtractor cell: difference plus borrow-out.
module sub_borrow #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    // The extra top bit of the widened difference is the borrow-out.
    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CNT_W = clog2(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quo;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_next_rem;
    logic [WIDTH-1:0] w_next_quo;
    logic             w_unused;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};

    sub_borrow #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .i_a      (w_shift),
        .i_b      ({1'b0, r_dvs}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_next_rem = w_borrow ? w_shift : w_diff;
    assign w_next_quo = {r_quo[WIDTH-2:0], ~w_borrow};

    // Remainder stays below the divisor, so these top bits are never consumed.
    assign w_unused = ^{r_rem[WIDTH], r_quo[WIDTH-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_dvd   <= bus.dividend;
                            r_dvs   <= bus.divisor;
                            r_rem   <= '0;
                            r_quo   <= '0;
                            r_count <= CNT_W'(WIDTH - 1);
                        end
                    end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    r_rem <= w_next_rem;
                    r_quo <= w_next_quo;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    if (r_count == '0) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_next_quo;
                        r_remainder <= w_next_rem[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference.
module tb_seq_divider;

    localparam int W = 8;
    localparam int RUN_LAT = W;

    logic clk;
    logic rst;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks;
    int nPassed;

    int           obsLat;
    int           obsBusy;
    int           obsDone;
    logic [W-1:0] obsQ;
    logic [W-1:0] obsR;
    logic         obsZ;
    logic [W-1:0] heldQ;
    logic [W-1:0] heldR;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; divide by zero yields all ones / dividend.
    function automatic void refDiv(input int a, input int b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic z);
        if (b == 0) begin
            q = '1;
            r = W'(a);
            z = 1'b1;
        end else begin
            q = W'(a / b);
            r = W'(a % b);
            z = 1'b0;
        end
    endfunction

    // Issues one start and watches the outputs until two cycles past the first done.
    // obsLat counts rising edges after the accepting edge until done is seen.
    task automatic applyStimulus(input int a, input int b, input int pulseAt);
        obsLat  = -1;
        obsBusy = 0;
        obsDone = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        @(posedge clk);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (obsLat < 0 && bus.busy) obsBusy++;
            if (bus.done) begin
                obsDone++;
                if (obsLat < 0) begin
                    obsLat = k;
                    obsQ   = bus.quotient;
                    obsR   = bus.remainder;
                    obsZ   = bus.div_by_zero;
                end
            end
            if (k == 0) begin
                bus.start    = 1'b0;
                bus.dividend = W'($urandom);
                bus.divisor  = W'($urandom);
            end
            if (k == pulseAt) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end else if (pulseAt >= 0 && k == pulseAt + 1) begin
                bus.start = 1'b0;
            end
            if (obsLat >= 0 && k == obsLat + 2) begin
                heldQ = bus.quotient;
                heldR = bus.remainder;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else nPassed++;
        nChecks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else nPassed++;
        nChecks++; if (bus.quotient !== '0) $display("[TB] FAIL reset_quotient: got %0d expected 0", bus.quotient); else nPassed++;
        nChecks++; if (bus.remainder !== '0) $display("[TB] FAIL reset_remainder: got %0d expected 0", bus.remainder); else nPassed++;
        nChecks++; if (bus.div_by_zero !== 1'b0) $display("[TB] FAIL reset_dbz: got %b expected 0", bus.div_by_zero); else nPassed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal;
        logic [W-1:0] q, r;
        logic         z;
        refDiv(100, 7, q, r, z);
        applyStimulus(100, 7, -1);
        nChecks++; if (obsLat != RUN_LAT) $display("[TB] FAIL normal_latency: got %0d expected %0d", obsLat, RUN_LAT); else nPassed++;
        nChecks++; if (obsDone != 1) $display("[TB] FAIL normal_done_count: got %0d expected 1", obsDone); else nPassed++;
        nChecks++; if (obsBusy != RUN_LAT) $display("[TB] FAIL normal_busy_cycles: got %0d expected %0d", obsBusy, RUN_LAT); else nPassed++;
        nChecks++; if (obsQ !== q) $display("[TB] FAIL normal_quotient: got %0d expected %0d", obsQ, q); else nPassed++;
        nChecks++; if (obsR !== r) $display("[TB] FAIL normal_remainder: got %0d expected %0d", obsR, r); else nPassed++;
        nChecks++; if (obsZ !== z) $display("[TB] FAIL normal_dbz: got %b expected %b", obsZ, z); else nPassed++;
        nChecks++; if (heldQ !== q || heldR !== r) $display("[TB] FAIL normal_hold: got %0d/%0d expected %0d/%0d", heldQ, heldR, q, r); else nPassed++;
    endtask

    task automatic test_boundary;
        int opA[3] = '{255, 3, 0};
        int opB[3] = '{1, 200, 9};
        logic [W-1:0] q, r;
        logic         z;
        for (int i = 0; i < 3; i++) begin
            refDiv(opA[i], opB[i], q, r, z);
            applyStimulus(opA[i], opB[i], -1);
            nChecks++; if (obsQ !== q) $display("[TB] FAIL boundary_quotient %0d/%0d: got %0d expected %0d", opA[i], opB[i], obsQ, q); else nPassed++;
            nChecks++; if (obsR !== r) $display("[TB] FAIL boundary_remainder %0d/%0d: got %0d expected %0d", opA[i], opB[i], obsR, r); else nPassed++;
        end
    endtask

    task automatic test_div_zero;
        logic [W-1:0] q, r;
        logic         z;
        refDiv(5, 0, q, r, z);
        applyStimulus(5, 0, -1);
        nChecks++; if (obsLat != 0) $display("[TB] FAIL dbz_latency: got %0d expected 0", obsLat); else nPassed++;
        nChecks++; if (obsBusy != 0) $display("[TB] FAIL dbz_busy_cycles: got %0d expected 0", obsBusy); else nPassed++;
        nChecks++; if (obsQ !== q) $display("[TB] FAIL dbz_quotient: got %0d expected %0d", obsQ, q); else nPassed++;
        nChecks++; if (obsR !== r) $display("[TB] FAIL dbz_remainder: got %0d expected %0d", obsR, r); else nPassed++;
        nChecks++; if (obsZ !== z) $display("[TB] FAIL dbz_flag: got %b expected %b", obsZ, z); else nPassed++;
        refDiv(9, 3, q, r, z);
        applyStimulus(9, 3, -1);
        nChecks++; if (obsQ !== q || obsR !== r) $display("[TB] FAIL after_dbz_result: got %0d/%0d expected %0d/%0d", obsQ, obsR, q, r); else nPassed++;
        nChecks++; if (obsZ !== z) $display("[TB] FAIL after_dbz_flag: got %b expected %b", obsZ, z); else nPassed++;
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] q, r;
        logic         z;
        refDiv(200, 9, q, r, z);
        applyStimulus(200, 9, 2);
        nChecks++; if (obsLat != RUN_LAT) $display("[TB] FAIL ignored_latency: got %0d expected %0d", obsLat, RUN_LAT); else nPassed++;
        nChecks++; if (obsDone != 1) $display("[TB] FAIL ignored_done_count: got %0d expected 1", obsDone); else nPassed++;
        nChecks++; if (obsQ !== q || obsR !== r) $display("[TB] FAIL ignored_result: got %0d/%0d expected %0d/%0d", obsQ, obsR, q, r); else nPassed++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] q1, r1, q2, r2;
        logic         z;
        int           seen;
        int           lat2;
        refDiv(100, 7, q1, r1, z);
        refDiv(81, 9, q2, r2, z);
        seen = 0;
        lat2 = -1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 8'd81;
        bus.divisor  = 8'd9;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        nChecks++; if (seen != 1) $display("[TB] FAIL b2b_first_done: got %0d expected 1", seen); else nPassed++;
        nChecks++; if (bus.quotient !== q1 || bus.remainder !== r1) $display("[TB] FAIL b2b_first_result: got %0d/%0d expected %0d/%0d", bus.quotient, bus.remainder, q1, r1); else nPassed++;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        nChecks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("[TB] FAIL b2b_accepted: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); else nPassed++;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat2 = k;
                break;
            end
        end
        nChecks++; if (lat2 != RUN_LAT) $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", lat2, RUN_LAT); else nPassed++;
        nChecks++; if (bus.quotient !== q2 || bus.remainder !== r2) $display("[TB] FAIL b2b_second_result: got %0d/%0d expected %0d/%0d", bus.quotient, bus.remainder, q2, r2); else nPassed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] q, r;
        logic         z;
        int           doneSeen;
        doneSeen = 0;
        refDiv(100, 7, q, r, z);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        nChecks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("[TB] FAIL midreset_flags: got busy=%b done=%b expected 0/0", bus.busy, bus.done); else nPassed++;
        nChecks++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) $display("[TB] FAIL midreset_results: got %0d/%0d/%b expected 0/0/0", bus.quotient, bus.remainder, bus.div_by_zero); else nPassed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) doneSeen++;
        end
        nChecks++; if (doneSeen != 0) $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", doneSeen); else nPassed++;
        applyStimulus(100, 7, -1);
        nChecks++; if (obsLat != RUN_LAT) $display("[TB] FAIL midreset_rerun_latency: got %0d expected %0d", obsLat, RUN_LAT); else nPassed++;
        nChecks++; if (obsQ !== q || obsR !== r) $display("[TB] FAIL midreset_rerun_result: got %0d/%0d expected %0d/%0d", obsQ, obsR, q, r); else nPassed++;
    endtask

    task automatic test_random;
        logic [W-1:0] q, r;
        logic         z;
        int           a, b, expLat;
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) b = 0;
            else if ($urandom_range(0, 1) == 0) b = int'($urandom_range(1, 15));
            else b = int'($urandom_range(1, 255));
            refDiv(a, b, q, r, z);
            expLat = (b == 0) ? 0 : RUN_LAT;
            applyStimulus(a, b, -1);
            nChecks++; if (obsLat != expLat) $display("[TB] FAIL rand_latency %0d/%0d: got %0d expected %0d", a, b, obsLat, expLat); else nPassed++;
            nChecks++; if (obsQ !== q) $display("[TB] FAIL rand_quotient %0d/%0d: got %0d expected %0d", a, b, obsQ, q); else nPassed++;
            nChecks++; if (obsR !== r) $display("[TB] FAIL rand_remainder %0d/%0d: got %0d expected %0d", a, b, obsR, r); else nPassed++;
            nChecks++; if (obsZ !== z) $display("[TB] FAIL rand_dbz %0d/%0d: got %b expected %b", a, b, obsZ, z); else nPassed++;
        end
    endtask

    initial begin
        nChecks = 0;
        nPassed = 0;
        test_reset();
        test_normal();
        test_boundary();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

    // Guards against a stuck run so the bench always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
